// File: rtl/rxpy_bitpacker_pkg.sv
// Shared types and defaults for the rx payload bit packer.
package rxpy_bitpacker_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, PACK = 2'd1, FLUSH = 2'd2} state_e;
  localparam int DW_DEF = 32;
  localparam int AW_DEF = 8;
  localparam int CNT_W  = 13;
endpackage

// File: rtl/rxpy_bitpacker_wordreg.sv
// Bit-indexed word accumulator: clear wins first, then the indexed bit is set the same cycle.
module rxpy_wordreg #(
  parameter int DW = 32,
  parameter int IW = $clog2(DW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          set_i,
  input  logic [IW-1:0] idx_i,
  input  logic          bit_i,
  output logic [DW-1:0] word_o
);
  logic [DW-1:0] word_q, word_d;

  always_comb begin
    word_d = clr_i ? '0 : word_q;
    if (set_i) word_d[idx_i] = bit_i;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) word_q <= '0;
    else     word_q <= word_d;

  assign word_o = word_q;
endmodule

// File: rtl/rxpy_bitpacker.sv
// Rx payload deserializer: packs serial bits LSB-first into buffer words.
// Optional payload length check enabled with `define RXPY_LENCHK_EN.
module rxpy_bitpacker
  import rxpy_bitpacker_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int AW        = AW_DEF,
  parameter int MAX_WORDS = 256
) (
  input  logic             clk_6M,
  input  logic             rst,
  input  logic             dec_py_period,
  input  logic             dec_pybit_valid,
  input  logic             dec_pybitin,
  input  logic             dec_py_endp,
`ifdef RXPY_LENCHK_EN
  input  logic [9:0]       dec_pylenByte,
  output logic             rxpy_lenerr,
`endif
  output logic [AW-1:0]    rxlnctrl_addr,
  output logic [DW-1:0]    rxlnctrl_din,
  output logic             rxlnctrl_we,
  output logic [CNT_W-1:0] rxpy_bitcnt,
  output logic             rxpy_done_p,
  output logic             rxpy_ovf
);
  localparam int IW = $clog2(DW);
  // One extra count bit so a completely full buffer is distinguishable from an empty word slot.
  localparam logic [CNT_W:0] CAP = (CNT_W+1)'(MAX_WORDS * DW);

  state_e         state_q, state_d;
  logic           period_q, pend_q, ovf_q;
  logic [CNT_W:0] cnt_q, cnt_d;
  logic [AW-1:0]  waddr_q;
  logic           start, abort, strobe, acc, full_bit, flush_part, clr;
  logic [DW-1:0]  word;

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE:  if (dec_py_period && !period_q) begin state_d = PACK; start = 1'b1; end
      PACK:  if (dec_py_endp) state_d = FLUSH;
             else if (!dec_py_period) begin state_d = IDLE; abort = 1'b1; end
      FLUSH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign strobe     = (state_q == PACK) && dec_pybit_valid;
  assign acc        = strobe && (cnt_q < CAP);
  assign full_bit   = acc && (&cnt_q[IW-1:0]);
  assign cnt_d      = start ? '0 : cnt_q + {{CNT_W{1'b0}}, acc};
  // A pending full-word write in FLUSH means endp came with the filling bit: no partial remains.
  assign flush_part = (state_q == FLUSH) && !pend_q && (|cnt_q[IW-1:0]);
  assign clr        = pend_q | start | abort | (state_q == FLUSH);

  always_ff @(posedge clk_6M or posedge rst)
    if (rst) begin
      state_q  <= IDLE;
      period_q <= 1'b0;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      waddr_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= dec_py_period;
      cnt_q    <= cnt_d;
      pend_q   <= full_bit;
      if (acc) waddr_q <= cnt_q[IW +: AW];
      if (start)                ovf_q <= 1'b0;
      else if (strobe && !acc)  ovf_q <= 1'b1;
    end

  rxpy_wordreg #(.DW(DW), .IW(IW)) u_wordreg (
    .clk    (clk_6M),
    .rst    (rst),
    .clr_i  (clr),
    .set_i  (acc),
    .idx_i  (cnt_q[IW-1:0]),
    .bit_i  (dec_pybitin),
    .word_o (word)
  );

  assign rxlnctrl_we   = pend_q | flush_part;
  assign rxlnctrl_addr = pend_q ? waddr_q : cnt_q[IW +: AW];
  assign rxlnctrl_din  = word;
  assign rxpy_done_p   = (state_q == FLUSH);
  assign rxpy_ovf      = ovf_q;
  assign rxpy_bitcnt   = cnt_q[CNT_W] ? {CNT_W{1'b1}} : cnt_q[CNT_W-1:0];

`ifdef RXPY_LENCHK_EN
  logic lenerr_q;
  always_ff @(posedge clk_6M or posedge rst)
    if (rst)                                       lenerr_q <= 1'b0;
    else if (start)                                lenerr_q <= 1'b0;
    else if ((state_q == PACK) && dec_py_endp)     lenerr_q <= (cnt_d != {1'b0, dec_pylenByte, 3'b000});
  assign rxpy_lenerr = lenerr_q;
`endif
endmodule

// File: tb/tb_rxpy_bitpacker.sv
// Scoreboard bench for rxpy_bitpacker: a bit-level model queues expected writes.
module tb_rxpy_bitpacker;
  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic        clk_6M = 1'b0, rst = 1'b1;
  logic        period = 1'b0, valid = 1'b0, bitin = 1'b0, endp = 1'b0;
  logic [7:0]  addr;
  logic [31:0] din;
  logic        we, done, ovf;
  logic [12:0] bitcnt;
`ifdef RXPY_LENCHK_EN
  logic [9:0]  lenbyte = 10'd0;
  logic        lenerr;
`endif

  exp_t        q[$];
  int          total = 0, bad = 0, we_cnt = 0, done_cnt = 0;
  int          m_cnt = 0;
  logic [31:0] m_word = '0;

  always #5 clk_6M = ~clk_6M;

  rxpy_bitpacker dut (
    .clk_6M          (clk_6M),
    .rst             (rst),
    .dec_py_period   (period),
    .dec_pybit_valid (valid),
    .dec_pybitin     (bitin),
    .dec_py_endp     (endp),
`ifdef RXPY_LENCHK_EN
    .dec_pylenByte   (lenbyte),
    .rxpy_lenerr     (lenerr),
`endif
    .rxlnctrl_addr   (addr),
    .rxlnctrl_din    (din),
    .rxlnctrl_we     (we),
    .rxpy_bitcnt     (bitcnt),
    .rxpy_done_p     (done),
    .rxpy_ovf        (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // One stimulus cycle; the model mirrors the buffer-write behaviour bit by bit.
  task automatic drv(input logic v, input logic b, input logic e);
    valid = v; bitin = b; endp = e;
    if (v && m_cnt < 8192) begin
      m_word[m_cnt % 32] = b;
      m_cnt++;
      if (m_cnt % 32 == 0) begin
        q.push_back('{addr: 8'((m_cnt - 1) / 32), data: m_word, last: e});
        m_word = '0;
      end
    end
    if (e && (m_cnt % 32 != 0)) begin
      q.push_back('{addr: 8'(m_cnt / 32), data: m_word, last: 1'b1});
      m_word = '0;
    end
    @(posedge clk_6M); #1;
    valid = 1'b0; endp = 1'b0;
  endtask

  task automatic start_py();
    period = 1'b1;
    m_cnt = 0; m_word = '0;
    @(posedge clk_6M); #1;
  endtask

  task automatic end_py();
    repeat (4) @(posedge clk_6M);
    #1 period = 1'b0;
    @(posedge clk_6M); #1;
  endtask

  task automatic send_word(input logic [31:0] w, input logic last_endp);
    for (int i = 0; i < 32; i++) drv(1'b1, w[i], last_endp && i == 31);
  endtask

  always @(negedge clk_6M) begin : mon
    exp_t e;
    if (!rst) begin
      if (we) begin
        we_cnt++;
        if (q.size() == 0) chk("we_unexpected", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("wr_addr", {24'd0, addr}, {24'd0, e.addr});
          chk("wr_data", din, e.data);
          chk("done_with_last", {31'd0, done}, {31'd0, e.last});
        end
      end
      if (done) done_cnt++;
    end
  end

  initial begin
    int w0, d0;
    repeat (3) @(posedge clk_6M);
    #1;
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_din", din, 32'd0);
    chk("rst_addr", {24'd0, addr}, 32'd0);
    chk("rst_bitcnt", {19'd0, bitcnt}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    rst = 1'b0;
    @(posedge clk_6M); #1;

    // Two full words, endp on the last bit
    w0 = we_cnt; d0 = done_cnt;
    start_py();
    send_word(32'hA5A5A5A5, 1'b0);
    send_word(32'h0000FFFF, 1'b1);
    end_py();
    chk("t1_we_cnt", we_cnt - w0, 32'd2);
    chk("t1_done_cnt", done_cnt - d0, 32'd1);
    chk("t1_q_empty", q.size(), 32'd0);

    // Abort: period drops without endp
    w0 = we_cnt; d0 = done_cnt;
    start_py();
    for (int i = 0; i < 8; i++) drv(1'b1, 1'b1, 1'b0);
    period = 1'b0;
    m_word = '0;
    repeat (4) @(posedge clk_6M);
    #1;
    chk("t3_no_we", we_cnt - w0, 32'd0);
    chk("t3_no_done", done_cnt - d0, 32'd0);

    // 40 ones: one full word plus a byte partial
    w0 = we_cnt; d0 = done_cnt;
    start_py();
    for (int i = 0; i < 40; i++) drv(1'b1, 1'b1, i == 39);
    end_py();
    chk("t2_bitcnt", {19'd0, bitcnt}, 32'd40);
    chk("t2_we_cnt", we_cnt - w0, 32'd2);
    chk("t2_done_cnt", done_cnt - d0, 32'd1);

    // Overflow past 256 words, endp on its own cycle
    w0 = we_cnt; d0 = done_cnt;
    start_py();
    for (int i = 0; i < 8200; i++) drv(1'b1, 1'($urandom), 1'b0);
    drv(1'b0, 1'b0, 1'b1);
    end_py();
    chk("t4_we_cnt", we_cnt - w0, 32'd256);
    chk("t4_done_cnt", done_cnt - d0, 32'd1);
    chk("t4_ovf", {31'd0, ovf}, 32'd1);
    chk("t4_bitcnt_sat", {19'd0, bitcnt}, 32'd8191);
    start_py();
    chk("t4_ovf_clr", {31'd0, ovf}, 32'd0);
    drv(1'b0, 1'b0, 1'b1);
    end_py();

    // Reset mid-payload
    w0 = we_cnt;
    start_py();
    for (int i = 0; i < 20; i++) drv(1'b1, 1'b1, 1'b0);
    rst = 1'b1; period = 1'b0;
    @(negedge clk_6M);
    chk("t5_we", {31'd0, we}, 32'd0);
    chk("t5_din", din, 32'd0);
    chk("t5_bitcnt", {19'd0, bitcnt}, 32'd0);
    chk("t5_done", {31'd0, done}, 32'd0);
    @(posedge clk_6M); #1;
    rst = 1'b0;
    chk("t5_no_we", we_cnt - w0, 32'd0);
    start_py();
    send_word(32'h12345678, 1'b1);
    end_py();
    chk("t5_we_after", we_cnt - w0, 32'd1);

`ifdef RXPY_LENCHK_EN
    lenbyte = 10'd5;
    start_py();
    for (int i = 0; i < 39; i++) drv(1'b1, 1'b0, i == 38);
    end_py();
    chk("t6_lenerr_39", {31'd0, lenerr}, 32'd1);
    start_py();
    for (int i = 0; i < 40; i++) drv(1'b1, 1'b0, i == 39);
    end_py();
    chk("t6_lenerr_40", {31'd0, lenerr}, 32'd0);
`endif

    chk("final_q_empty", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
